// File: rtl/conv3x3_mac_pipe.sv
// 3x3 fixed-point convolution MAC: multiply / row-sum / total+bias / round+saturate,
// all stages gated by a single downstream-driven advance, with tlast carried alongside the data.
module conv3x3_mac_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic signed [DATA_WIDTH-1:0] in_window_00,
  input  logic signed [DATA_WIDTH-1:0] in_window_01,
  input  logic signed [DATA_WIDTH-1:0] in_window_02,
  input  logic signed [DATA_WIDTH-1:0] in_window_10,
  input  logic signed [DATA_WIDTH-1:0] in_window_11,
  input  logic signed [DATA_WIDTH-1:0] in_window_12,
  input  logic signed [DATA_WIDTH-1:0] in_window_20,
  input  logic signed [DATA_WIDTH-1:0] in_window_21,
  input  logic signed [DATA_WIDTH-1:0] in_window_22,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   IMAGE_SIZE,
  input  logic                         w_we,
  input  logic [3:0]                   w_addr,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  typedef logic signed [DATA_WIDTH-1:0]   data_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;

  localparam acc_t  RND   = acc_t'((64'd1 << FRAC_BITS) >> 1);
  localparam data_t D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam data_t D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic  advance;
  logic  accept;
  data_t win [9];

  data_t weight_q [9];
  data_t bias_q;

  logic [6:0] col_q;
  logic [6:0] col_d;
  logic       last_d;

  prod_t prod_d    [9];
  prod_t s1_prod_q [9];
  data_t s1_bias_q;
  logic  s1_valid_q;
  logic  s1_last_q;

  acc_t  row_d    [3];
  acc_t  s2_row_q [3];
  data_t s2_bias_q;
  logic  s2_valid_q;
  logic  s2_last_q;

  acc_t  total_d;
  acc_t  s3_total_q;
  logic  s3_valid_q;
  logic  s3_last_q;

  acc_t  rounded;
  data_t out_d;

  assign advance  = !m_axis_tvalid | m_axis_tready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  always_comb begin
    win[0] = in_window_00;
    win[1] = in_window_01;
    win[2] = in_window_02;
    win[3] = in_window_10;
    win[4] = in_window_11;
    win[5] = in_window_12;
    win[6] = in_window_20;
    win[7] = in_window_21;
    win[8] = in_window_22;
  end

  always_comb begin
    last_d = ({1'b0, col_q} == (IMAGE_SIZE - 8'd1));
    col_d  = last_d ? '0 : col_q + 7'd1;
  end

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      prod_d[i] = prod_t'(win[i]) * prod_t'(weight_q[i]);
    end
    for (int unsigned r = 0; r < 3; r++) begin
      row_d[r] = acc_t'(s1_prod_q[3*r]) + acc_t'(s1_prod_q[3*r+1]) + acc_t'(s1_prod_q[3*r+2]);
    end
    total_d = s2_row_q[0] + s2_row_q[1] + s2_row_q[2] + (acc_t'(s2_bias_q) <<< FRAC_BITS);
    rounded = (s3_total_q + RND) >>> FRAC_BITS;
    if (rounded > acc_t'(D_MAX)) begin
      out_d = D_MAX;
    end else if (rounded < acc_t'(D_MIN)) begin
      out_d = D_MIN;
    end else begin
      out_d = rounded[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 9; i++) begin
        weight_q[i] <= '0;
      end
      bias_q <= '0;
    end else if (w_we) begin
      if (w_addr < 4'd9) begin
        weight_q[w_addr] <= w_data;
      end else if (w_addr == 4'd9) begin
        bias_q <= w_data;
      end
    end
  end

  // Bias is sampled with the window and carried along so a later write cannot touch in-flight data.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      col_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        s1_prod_q[i] <= '0;
      end
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bias_q  <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        s2_row_q[r] <= '0;
      end
      s3_valid_q    <= 1'b0;
      s3_last_q     <= 1'b0;
      s3_total_q    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (accept) begin
        col_q <= col_d;
      end
      if (advance) begin
        s1_valid_q <= in_valid;
        s1_last_q  <= in_valid & last_d;
        s1_bias_q  <= bias_q;
        for (int unsigned i = 0; i < 9; i++) begin
          s1_prod_q[i] <= prod_d[i];
        end
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_bias_q  <= s1_bias_q;
        for (int unsigned r = 0; r < 3; r++) begin
          s2_row_q[r] <= row_d[r];
        end
        s3_valid_q    <= s2_valid_q;
        s3_last_q     <= s2_last_q;
        s3_total_q    <= total_d;
        m_axis_tvalid <= s3_valid_q;
        m_axis_tlast  <= s3_last_q;
        m_axis_tdata  <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// Scoreboard bench for conv3x3_mac_pipe: a negedge monitor predicts each accepted window
// from its own coefficient/column model and compares it when the result is handed off.
module tb_conv3x3_mac_pipe;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int AW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 Reset;
  logic signed [DW-1:0] win [9];
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           IMAGE_SIZE;
  logic                 w_we;
  logic [3:0]           w_addr;
  logic signed [DW-1:0] w_data;
  logic signed [DW-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic                 l;
    logic signed [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   mw [9];
  int   mb;
  int   mcol;
  bit   rand_rdy;
  bit   tl_mode;
  int   tl_idx;
  bit   prev_stall;
  logic signed [DW-1:0] prev_d;
  logic prev_l;

  conv3x3_mac_pipe #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .in_window_00  (win[0]),
    .in_window_01  (win[1]),
    .in_window_02  (win[2]),
    .in_window_10  (win[3]),
    .in_window_11  (win[4]),
    .in_window_12  (win[5]),
    .in_window_20  (win[6]),
    .in_window_21  (win[7]),
    .in_window_22  (win[8]),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .IMAGE_SIZE    (IMAGE_SIZE),
    .w_we          (w_we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] ref_pix();
    longint acc = 0;
    longint maxv = (longint'(1) << (DW-1)) - 1;
    longint minv = -(longint'(1) << (DW-1));
    for (int i = 0; i < 9; i++) begin
      acc += longint'(win[i]) * longint'(mw[i]);
    end
    acc += longint'(mb) * (longint'(1) << FB);
    acc = (acc + (longint'(1) << (FB-1))) >>> FB;
    if (acc > maxv) acc = maxv;
    if (acc < minv) acc = minv;
    return acc[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!Reset) begin
      q.delete();
      for (int i = 0; i < 9; i++) mw[i] = 0;
      mb = 0;
      mcol = 0;
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      bit   lst;
      check("in_ready", in_ready, !(tvalid && !tready));
      if (prev_stall) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, prev_d);
        check("hold_last", tlast, prev_l);
      end
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("data", tdata, e.d);
          check("last", tlast, e.l);
        end
        if (tl_mode) begin
          tl_idx++;
          check("tlast_pos", tlast, (tl_idx % 4) == 0);
        end
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      if (in_valid && in_ready) begin
        lst = (mcol == int'(IMAGE_SIZE) - 1);
        mcol = lst ? 0 : mcol + 1;
        e.d = ref_pix();
        e.l = lst;
        q.push_back(e);
      end
      if (w_we && w_addr < 4'd9) mw[w_addr] = int'(w_data);
      else if (w_we && w_addr == 4'd9) mb = int'(w_data);
    end
    if (!tl_mode) tl_idx = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) tready = $urandom_range(0, 1) != 0;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) win[i] = DW'(int'($urandom_range(0, 4000)) - 2000);
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [DW-1:0] d);
    w_we = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic signed [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    w_we = we;
    w_addr = a;
    w_data = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = in_ready;
      tick();
      w_we = 1'b0;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 400 && q.size() != 0; t++) tick();
    check("drain", q.size(), 0);
    tick();
  endtask

  task automatic single(input string tag, input longint expv);
    bit seen = 1'b0;
    tready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (tvalid) seen = 1'b1;
      else tick();
    end
    if (seen) check(tag, tdata, expv);
    else check("single_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) win[i] = '0;
    IMAGE_SIZE = 8'd128;
    w_we = 1'b0;
    w_addr = '0;
    w_data = '0;
    tready = 1'b1;
    rand_rdy = 1'b0;
    tl_mode = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_in_ready", in_ready, 1);
    Reset = 1'b1;
    tick();
    tick();

    // identity with exact 3-cycle latency
    write_coef(4'd4, 16'sd256);
    rand_win();
    win[4] = 16'sd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("latency_early", tvalid, 0);
      tick();
    end
    check("latency_valid", tvalid, 1);
    check("identity", tdata, 100);
    tick();

    // rounding
    write_coef(4'd4, 16'sd0);
    write_coef(4'd0, 16'sd128);
    rand_win();
    win[0] = 16'sd3;
    single("round_pos", 2);
    win[0] = -16'sd3;
    single("round_neg", -1);

    // saturation
    for (int a = 0; a < 9; a++) write_coef(4'(a), 16'sd32767);
    for (int i = 0; i < 9; i++) win[i] = 16'sd32767;
    single("sat_pos", 32767);
    for (int i = 0; i < 9; i++) win[i] = -16'sd32768;
    single("sat_neg", -32768);

    // bias alone, then an out-of-range address must not disturb it
    for (int a = 0; a < 9; a++) write_coef(4'(a), 16'sd0);
    write_coef(4'd9, 16'sd5);
    rand_win();
    single("bias_only", 5);
    write_coef(4'd12, 16'sd1234);
    write_coef(4'd15, -16'sd77);
    single("bad_addr", 5);

    // random backpressure with coefficient writes and an IMAGE_SIZE change mid-row
    for (int a = 0; a < 9; a++) write_coef(4'(a), DW'(int'($urandom_range(0, 600)) - 300));
    write_coef(4'd9, DW'(int'($urandom_range(0, 200)) - 100));
    IMAGE_SIZE = 8'd5;
    rand_rdy = 1'b1;
    for (int n = 0; n < 80; n++) begin
      rand_win();
      if (n == 41) IMAGE_SIZE = 8'd3;
      if ($urandom_range(0, 5) == 0)
        send(1'b1, 4'($urandom_range(0, 15)), DW'(int'($urandom_range(0, 600)) - 300));
      else
        send(1'b0, 4'd0, 16'sd0);
    end
    drain();
    rand_rdy = 1'b0;
    tready = 1'b1;
    tick();

    // reset with results in flight
    for (int n = 0; n < 4; n++) begin
      rand_win();
      send(1'b0, 4'd0, 16'sd0);
    end
    check("pre_reset_valid", tvalid, 1);
    #1;
    Reset = 1'b0;
    rand_win();
    #1;
    check("reset_async_valid", tvalid, 0);
    check("reset_async_data", tdata, 0);
    check("reset_in_ready", in_ready, 1);
    tick();
    tick();
    Reset = 1'b1;
    in_valid = 1'b0;

    // tlast on a 4-pixel row right after reset
    IMAGE_SIZE = 8'd4;
    write_coef(4'd0, 16'sd256);
    write_coef(4'd8, -16'sd128);
    write_coef(4'd9, 16'sd3);
    repeat (6) tick();
    check("post_reset_idle", tvalid, 0);
    tl_mode = 1'b1;
    rand_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rand_win();
      send(1'b0, 4'd0, 16'sd0);
    end
    drain();
    check("tlast_count", tl_idx, 12);
    tl_mode = 1'b0;
    rand_rdy = 1'b0;
    tready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
